// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the MIPS execute stage.
// Pure declarations, no logic latency.
// No flow control of its own.
package ex_stage_pkg;

    localparam int WORD = 32;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ORI   = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    // mult/multu/div/divu occupy 0x18..0x1B; the low two bits select the op
    function automatic logic is_mdu_funct(input logic [5:0] f);
        return (f[5:2] == F_MULT[5:2]);
    endfunction

endpackage

// File: rtl/ex_stage_mdu.sv
// Iterative multiply/divide unit with HI/LO registers, one result bit per cycle.
// Latency: start cycle + MDU_ITER busy cycles, HI/LO written at the end of the last busy cycle.
// Backpressure: o_stall holds the pipeline front while starting or busy; abort drops it at once.
module ex_stage_mdu
    import ex_stage_pkg::*;
#(
    parameter int MDU_ITER = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic [1:0]      i_op,
    input  logic [WORD-1:0] i_a,
    input  logic [WORD-1:0] i_b,
    output logic            o_stall,
    output logic            o_done,
    output logic [WORD-1:0] o_hi,
    output logic [WORD-1:0] o_lo
);

    localparam int CW = (MDU_ITER > 2) ? $clog2(MDU_ITER) : 1;

    mdu_state_e        r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [2*WORD-1:0] r_acc, w_acc_nxt;
    logic [WORD-1:0]   r_b, r_a_raw, r_hi, r_lo, w_hi_nxt, w_lo_nxt;
    logic [WORD-1:0]   w_a_mag, w_b_mag, w_dif;
    logic [WORD:0]     w_sum, w_rem;
    logic              r_is_div, r_neg_res, r_neg_rem, w_a_neg, w_b_neg, w_ge, w_last;

    // Signed ops work on magnitudes; op[0]=1 means unsigned
    assign w_a_neg = ~i_op[0] & i_a[WORD-1];
    assign w_b_neg = ~i_op[0] & i_b[WORD-1];
    assign w_a_mag = w_a_neg ? -i_a : i_a;
    assign w_b_mag = w_b_neg ? -i_b : i_b;

    // FSM next state and stall request
    always_comb begin
        w_state_nxt = r_state;
        o_stall     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            MDU_IDLE: if (i_start) begin
                w_state_nxt = MDU_BUSY;
                o_stall     = 1'b1;
            end
            MDU_BUSY: if (i_abort) begin
                w_state_nxt = MDU_IDLE;
            end else begin
                o_stall = 1'b1;
                if (r_cnt == CW'(MDU_ITER - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = MDU_DONE;
                end
            end
            default: w_state_nxt = MDU_IDLE;
        endcase
    end

    // One shift-add (multiply) or restoring-subtract (divide) step
    always_comb begin
        w_sum = {1'b0, r_acc[2*WORD-1:WORD]} + (r_acc[0] ? {1'b0, r_b} : '0);
        // partial remainder needs 33 bits once shifted, since divisor may exceed 2^31
        w_rem = r_acc[2*WORD-1:WORD-1];
        w_ge  = (w_rem >= {1'b0, r_b});
        w_dif = w_rem[WORD-1:0] - r_b;
        if (r_is_div)
            w_acc_nxt = {(w_ge ? w_dif : w_rem[WORD-1:0]), r_acc[WORD-2:0], w_ge};
        else
            w_acc_nxt = {w_sum, r_acc[WORD-1:1]};
    end

    // Final sign fix-up and divide-by-zero result
    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (!r_is_div) begin
            {w_hi_nxt, w_lo_nxt} = r_neg_res ? -w_acc_nxt : w_acc_nxt;
        end else if (r_b == '0) begin
            w_hi_nxt = r_a_raw;
            w_lo_nxt = '1;
        end else begin
            w_lo_nxt = r_neg_res ? -w_acc_nxt[WORD-1:0] : w_acc_nxt[WORD-1:0];
            w_hi_nxt = r_neg_rem ? -w_acc_nxt[2*WORD-1:WORD] : w_acc_nxt[2*WORD-1:WORD];
        end
    end

    // State, operand latch, iteration and HI/LO update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= MDU_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_b       <= '0;
            r_a_raw   <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == MDU_IDLE && i_start) begin
                r_cnt     <= '0;
                r_acc     <= {{WORD{1'b0}}, w_a_mag};
                r_b       <= w_b_mag;
                r_a_raw   <= i_a;
                r_is_div  <= i_op[1];
                r_neg_res <= w_a_neg ^ w_b_neg;
                r_neg_rem <= w_a_neg;
            end else if (r_state == MDU_BUSY && !i_abort) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_hi <= w_hi_nxt;
                    r_lo <= w_lo_nxt;
                end
            end
        end
    end

    assign o_done = (r_state == MDU_DONE);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, branch target, destination select, EX/MEM register, HI/LO mult/div.
// Latency: 1 cycle for ALU ops; mult/div hold the stage for 1 + MDU_ITER cycles then leave.
// Backpressure: stall asserts while the MDU starts or iterates; flush overrides and squashes.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int MDU_ITER = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            RegDst,
    input  logic            ALUSrc,
    input  logic            Branch_in,
    input  logic            MemRead_in,
    input  logic            MemWrite_in,
    input  logic            RegWrite_in,
    input  logic            MemtoReg_in,
    input  logic [1:0]      ALUOp,
    input  logic [WORD-1:0] PCplus4,
    input  logic [WORD-1:0] ReadData1,
    input  logic [WORD-1:0] ReadData2,
    input  logic [WORD-1:0] SignExtImm,
    input  logic [4:0]      Rt,
    input  logic [4:0]      Rd,
    output logic            stall,
    output logic            zero,
    output logic            Branch,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            RegWrite_out,
    output logic            MemtoReg_out,
    output logic [4:0]      RegDstAddress_out,
    output logic [WORD-1:0] BranchTarget,
    output logic [WORD-1:0] ALUResult_out,
    output logic [WORD-1:0] MemWriteData
);

    logic [5:0]      w_funct;
    logic [4:0]      w_shamt;
    logic [WORD-1:0] w_opb, w_result, w_hi, w_lo;
    logic            w_known, w_mdu_start, w_mdu_done, w_bubble, w_kill;

    assign w_funct = SignExtImm[5:0];
    assign w_shamt = SignExtImm[10:6];
    assign w_opb   = ALUSrc ? SignExtImm : ReadData2;

    // No MDU start while reset is held so stall stays low in the reset state
    assign w_mdu_start = reset & ~flush & (ALUOp == ALUOP_RTYPE) & is_mdu_funct(w_funct);

    ex_stage_mdu #(.MDU_ITER(MDU_ITER)) u_mdu (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_mdu_start),
        .i_abort (flush),
        .i_op    (w_funct[1:0]),
        .i_a     (ReadData1),
        .i_b     (ReadData2),
        .o_stall (stall),
        .o_done  (w_mdu_done),
        .o_hi    (w_hi),
        .o_lo    (w_lo)
    );

    // ALU control decode and operation
    always_comb begin
        w_result = '0;
        w_known  = 1'b1;
        case (aluop_e'(ALUOp))
            ALUOP_ADD: w_result = ReadData1 + w_opb;
            ALUOP_SUB: w_result = ReadData1 - w_opb;
            ALUOP_ORI: w_result = ReadData1 | {16'b0, SignExtImm[15:0]};
            ALUOP_RTYPE: begin
                case (w_funct)
                    F_ADD, F_ADDU: w_result = ReadData1 + w_opb;
                    F_SUB, F_SUBU: w_result = ReadData1 - w_opb;
                    F_AND:  w_result = ReadData1 & w_opb;
                    F_OR:   w_result = ReadData1 | w_opb;
                    F_XOR:  w_result = ReadData1 ^ w_opb;
                    F_NOR:  w_result = ~(ReadData1 | w_opb);
                    F_SLT:  w_result = {{(WORD-1){1'b0}}, $signed(ReadData1) < $signed(w_opb)};
                    F_SLTU: w_result = {{(WORD-1){1'b0}}, ReadData1 < w_opb};
                    F_SLL:  w_result = ReadData2 << w_shamt;
                    F_SRL:  w_result = ReadData2 >> w_shamt;
                    F_SRA:  w_result = $unsigned($signed(ReadData2) >>> w_shamt);
                    F_MFHI: w_result = w_hi;
                    F_MFLO: w_result = w_lo;
                    F_MULT, F_MULTU, F_DIV, F_DIVU: w_result = '0;
                    default: w_known = 1'b0;
                endcase
            end
            default: w_result = '0;
        endcase
    end

    // Bubble while stalled or squashed; a finishing mult/div leaves without side effects
    assign w_bubble = flush | stall;
    assign w_kill   = w_mdu_done | ~w_known;

    // EX/MEM pipeline register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero              <= 1'b0;
            Branch            <= 1'b0;
            MemRead           <= 1'b0;
            MemWrite          <= 1'b0;
            RegWrite_out      <= 1'b0;
            MemtoReg_out      <= 1'b0;
            RegDstAddress_out <= '0;
            BranchTarget      <= '0;
            ALUResult_out     <= '0;
            MemWriteData      <= '0;
        end else begin
            zero              <= ~w_bubble & (w_result == '0);
            Branch            <= ~w_bubble & Branch_in;
            MemRead           <= ~w_bubble & ~w_mdu_done & MemRead_in;
            MemWrite          <= ~w_bubble & ~w_mdu_done & MemWrite_in;
            RegWrite_out      <= ~w_bubble & ~w_kill & RegWrite_in;
            MemtoReg_out      <= ~w_bubble & MemtoReg_in;
            RegDstAddress_out <= RegDst ? Rd : Rt;
            BranchTarget      <= PCplus4 + (SignExtImm << 2);
            ALUResult_out     <= w_result;
            MemWriteData      <= ReadData2;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed scoreboard bench for ex_stage: expected EX/MEM contents queued at issue, checked after the edge.
// Covers ALU ops, branch target, mult/div with HI/LO, flush and reset during iteration.
// Drives on the falling edge, samples 1 time unit after the rising edge.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset, flush, RegDst, ALUSrc;
    logic        Branch_in, MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in;
    logic [1:0]  ALUOp;
    logic [31:0] PCplus4, ReadData1, ReadData2, SignExtImm;
    logic [4:0]  Rt, Rd;
    logic        stall, zero, Branch, MemRead, MemWrite, RegWrite_out, MemtoReg_out;
    logic [4:0]  RegDstAddress_out;
    logic [31:0] BranchTarget, ALUResult_out, MemWriteData;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [4:0]  ctl;   // {Branch, MemRead, MemWrite, RegWrite, MemtoReg}
        logic        zero;
        logic        chk_zero;
        logic        chk_data;
        logic [4:0]  dst;
        logic [31:0] bt;
        logic [31:0] res;
        logic [31:0] wd;
    } exp_t;

    exp_t sbq[$];

    ex_stage #(.MDU_ITER(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .Branch_in(Branch_in), .MemRead_in(MemRead_in),
        .MemWrite_in(MemWrite_in), .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .ALUOp(ALUOp), .PCplus4(PCplus4), .ReadData1(ReadData1), .ReadData2(ReadData2),
        .SignExtImm(SignExtImm), .Rt(Rt), .Rd(Rd), .stall(stall), .zero(zero),
        .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite_out(RegWrite_out),
        .MemtoReg_out(MemtoReg_out), .RegDstAddress_out(RegDstAddress_out),
        .BranchTarget(BranchTarget), .ALUResult_out(ALUResult_out), .MemWriteData(MemWriteData)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ex_full(input string tag, input logic [31:0] res, input logic z,
                                     input logic [4:0] dst, input logic [31:0] bt,
                                     input logic [31:0] wd, input logic [4:0] ctl);
        exp_t e;
        e.tag = tag; e.ctl = ctl; e.zero = z; e.chk_zero = 1'b1; e.chk_data = 1'b1;
        e.dst = dst; e.bt = bt; e.res = res; e.wd = wd;
        return e;
    endfunction

    function automatic exp_t ex_ctl(input string tag, input logic chkz);
        exp_t e;
        e.tag = tag; e.ctl = 5'b0; e.zero = 1'b0; e.chk_zero = chkz; e.chk_data = 1'b0;
        e.dst = 5'd0; e.bt = 32'd0; e.res = 32'd0; e.wd = 32'd0;
        return e;
    endfunction

    task automatic sb_check();
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        e = sbq.pop_front();
        chk({e.tag, "_ctl"}, 32'({Branch, MemRead, MemWrite, RegWrite_out, MemtoReg_out}), 32'(e.ctl));
        if (e.chk_zero) chk({e.tag, "_zero"}, 32'(zero), 32'(e.zero));
        if (e.chk_data) begin
            chk({e.tag, "_res"}, ALUResult_out, e.res);
            chk({e.tag, "_bt"},  BranchTarget, e.bt);
            chk({e.tag, "_dst"}, 32'(RegDstAddress_out), 32'(e.dst));
            chk({e.tag, "_wd"},  MemWriteData, e.wd);
        end
    endtask

    task automatic step(input exp_t e);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        sb_check();
    endtask

    task automatic idle_inputs();
        flush = 1'b0; RegDst = 1'b0; ALUSrc = 1'b0; ALUOp = 2'b00;
        {Branch_in, MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in} = 5'b0;
        PCplus4 = 32'd0; ReadData1 = 32'd0; ReadData2 = 32'd0; SignExtImm = 32'd0;
        Rt = 5'd0; Rd = 5'd0;
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] imm, input logic [31:0] a,
                         input logic [31:0] b, input logic src, input logic [4:0] ctl);
        @(negedge clk);
        idle_inputs();
        ALUOp = op; SignExtImm = imm; ReadData1 = a; ReadData2 = b; ALUSrc = src;
        {Branch_in, MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in} = ctl;
        RegDst = 1'b1; Rt = 5'd9; Rd = 5'd3; PCplus4 = 32'h40;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 32'({zero, Branch, MemRead, MemWrite, RegWrite_out, MemtoReg_out}), 32'd0);
        chk({tag, "_dst"}, 32'(RegDstAddress_out), 32'd0);
        chk({tag, "_bt"},  BranchTarget, 32'd0);
        chk({tag, "_res"}, ALUResult_out, 32'd0);
        chk({tag, "_wd"},  MemWriteData, 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
    endtask

    // mfhi then mflo; bt = 0x40 + (funct << 2)
    task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        drive(2'b10, 32'h10, 32'd0, 32'd0, 1'b0, 5'b00010);
        step(ex_full({tag, "_mfhi"}, hi, hi == 32'd0, 5'd3, 32'h80, 32'd0, 5'b00010));
        drive(2'b10, 32'h12, 32'd0, 32'd0, 1'b0, 5'b00010);
        step(ex_full({tag, "_mflo"}, lo, lo == 32'd0, 5'd3, 32'h88, 32'd0, 5'b00010));
    endtask

    // abort_at < 0: run to completion; otherwise flush (or reset) after abort_at stall cycles
    task automatic run_mdu(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] f, input int abort_at, input bit use_reset);
        int n;
        drive(2'b10, {26'd0, f}, a, b, 1'b0, 5'b01110);
        n = 0;
        while (n < 100) begin
            #1;
            if (n == abort_at) break;
            if (stall !== 1'b1) break;
            sbq.push_back(ex_ctl({tag, "_bubble"}, 1'b1));
            @(posedge clk);
            #1;
            sb_check();
            @(negedge clk);
            n++;
        end
        if (abort_at < 0) begin
            chk({tag, "_stall_cycles"}, 32'(n), 32'd33);
            step(ex_ctl({tag, "_done"}, 1'b0));
        end else if (!use_reset) begin
            flush = 1'b1;
            #1;
            chk({tag, "_flush_stall"}, 32'(stall), 32'd0);
            step(ex_ctl({tag, "_flushed"}, 1'b1));
        end else begin
            reset = 1'b0;
            #1;
            chk_all_zero({tag, "_rst"});
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // add 5+7, imm holds funct 0x20 -> bt 0x40 + 0x80
        drive(2'b10, 32'h20, 32'd5, 32'd7, 1'b0, 5'b00010);
        step(ex_full("add", 32'd12, 1'b0, 5'd3, 32'hC0, 32'd7, 5'b00010));

        // beq path
        drive(2'b01, 32'h4, 32'd9, 32'd9, 1'b0, 5'b10000);
        PCplus4 = 32'h100;
        step(ex_full("beq", 32'd0, 1'b1, 5'd3, 32'h110, 32'd9, 5'b10000));

        drive(2'b10, 32'h22, 32'd3, 32'd5, 1'b0, 5'b00010);
        step(ex_full("sub_wrap", 32'hFFFF_FFFE, 1'b0, 5'd3, 32'hC8, 32'd5, 5'b00010));

        drive(2'b10, 32'h2A, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'b00010);
        step(ex_full("slt", 32'd1, 1'b0, 5'd3, 32'hE8, 32'd1, 5'b00010));

        drive(2'b10, 32'h2B, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'b00010);
        step(ex_full("sltu", 32'd0, 1'b1, 5'd3, 32'hEC, 32'd1, 5'b00010));

        // shamt 4: imm = (4 << 6) | funct
        drive(2'b10, 32'h103, 32'd0, 32'h8000_0000, 1'b0, 5'b00010);
        step(ex_full("sra", 32'hF800_0000, 1'b0, 5'd3, 32'h44C, 32'h8000_0000, 5'b00010));

        drive(2'b10, 32'h102, 32'd0, 32'h8000_0000, 1'b0, 5'b00010);
        step(ex_full("srl", 32'h0800_0000, 1'b0, 5'd3, 32'h448, 32'h8000_0000, 5'b00010));

        drive(2'b10, 32'h27, 32'h0F0F_0000, 32'h00FF_00FF, 1'b0, 5'b00010);
        step(ex_full("nor", 32'hF000_FF00, 1'b0, 5'd3, 32'hDC, 32'h00FF_00FF, 5'b00010));

        // ori zero-extends the immediate
        drive(2'b11, 32'hFFFF_8001, 32'hF0, 32'hDEAD, 1'b1, 5'b00010);
        step(ex_full("ori", 32'h0000_80F1, 1'b0, 5'd3, 32'hFFFE_0044, 32'hDEAD, 5'b00010));

        // unknown funct: result 0 and no register write
        drive(2'b10, 32'h3F, 32'd5, 32'd7, 1'b0, 5'b00010);
        step(ex_full("unknown", 32'd0, 1'b1, 5'd3, 32'h13C, 32'd7, 5'b00000));

        // load-style add with negative offset, Rt destination
        drive(2'b00, 32'hFFFF_FFFC, 32'h1000, 32'h55, 1'b1, 5'b01011);
        RegDst = 1'b0;
        step(ex_full("lw", 32'hFFC, 1'b0, 5'd9, 32'h30, 32'h55, 5'b01011));

        drive(2'b00, 32'h8, 32'h2000, 32'hCAFE, 1'b1, 5'b00100);
        step(ex_full("sw", 32'h2008, 1'b0, 5'd3, 32'h60, 32'hCAFE, 5'b00100));

        drive(2'b10, 32'h20, 32'd5, 32'd7, 1'b0, 5'b00010);
        flush = 1'b1;
        step(ex_ctl("flush_add", 1'b1));

        run_mdu("mult", 32'hFFFF_FFFE, 32'd3, 6'h18, -1, 1'b0);
        read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        run_mdu("multu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h19, -1, 1'b0);
        read_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        run_mdu("divu0", 32'd7, 32'd0, 6'h1B, -1, 1'b0);
        read_hilo("divu0", 32'd7, 32'hFFFF_FFFF);

        run_mdu("div", 32'hFFFF_FFF9, 32'd2, 6'h1A, -1, 1'b0);
        read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_mdu("divu_big", 32'hFFFF_FFFF, 32'h8000_0001, 6'h1B, -1, 1'b0);
        read_hilo("divu_big", 32'h7FFF_FFFE, 32'h0000_0001);

        // flush mid-iteration leaves HI/LO from the previous divide
        run_mdu("mult_flush", 32'd100, 32'd100, 6'h18, 10, 1'b0);
        read_hilo("after_flush", 32'h7FFF_FFFE, 32'h0000_0001);

        // reset mid-iteration clears everything
        run_mdu("multu_rst", 32'd5, 32'd6, 6'h19, 5, 1'b1);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        read_hilo("after_rst", 32'd0, 32'd0);
        drive(2'b10, 32'h20, 32'd5, 32'd7, 1'b0, 5'b00010);
        step(ex_full("add_after_rst", 32'd12, 1'b0, 5'd3, 32'hC0, 32'd7, 5'b00010));

        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline: sits between the ID/EX buffer and the memory stage and feeds it through an internal EX/MEM register. Performs ALU control decode, ALU operation, branch-target computation and destination-register selection. Also owns an iterative multiply/divide unit with HI/LO registers that stalls the front of the pipeline while busy.

## Interface
- MDU_ITER, 32, multiply/divide iterations (one result bit per cycle)
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- flush  in  1  squash the EX instruction (branch taken in MEM)
- RegDst, ALUSrc, Branch_in, MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in  in  1 each  ID/EX control
- ALUOp  in  2  00 add, 01 sub, 10 R-type by funct, 11 OR with zero-extended imm
- PCplus4, ReadData1, ReadData2, SignExtImm  in  `WORD each  ID/EX data
- Rt, Rd  in  5 each  candidate destination registers
- stall  out  1  hold PC, IF/ID, ID/EX (MDU in progress)
- zero, Branch, MemRead, MemWrite, RegWrite_out, MemtoReg_out  out  1 each  registered EX/MEM control
- RegDstAddress_out  out  5  registered destination
- BranchTarget, ALUResult_out, MemWriteData  out  `WORD each  registered EX/MEM data

## Operation
- funct = SignExtImm[5:0], shamt = SignExtImm[10:6]; operand B = ALUSrc ? imm : ReadData2 (ALUOp 11 uses {16'b0, SignExtImm[15:0]}).
- R-type funct: 20/21 add, 22/23 sub (wrap, no overflow trap), 24 and, 25 or, 26 xor, 27 nor, 2A slt signed, 2B sltu, 00 sll, 02 srl, 03 sra (shift ReadData2 by shamt), 10 mfhi, 12 mflo, 18 mult, 19 multu, 1A div, 1B divu. Unknown funct -> result 0, RegWrite forced 0.
- zero = (ALU result == 0); BranchTarget = PCplus4 + (SignExtImm << 2); RegDstAddress = RegDst ? Rd : Rt; MemWriteData = ReadData2.
- MDU FSM: IDLE, BUSY, DONE.
  - IDLE + valid mult/div funct (ALUOp 10) and no flush: latch operand magnitudes and sign, stall=1, -> BUSY, count=0.
  - BUSY: one shift-add / restoring-subtract step per cycle, stall=1; after iteration MDU_ITER-1 write HI/LO, -> DONE.
  - DONE: stall=0, instruction passes to EX/MEM with RegWrite/MemRead/MemWrite=0, -> IDLE.
- Signed ops: operate on magnitudes, negate product if signs differ; quotient truncates toward zero, remainder takes dividend sign.
- Divide by zero: LO=32'hFFFFFFFF, HI=dividend (no trap).
- flush: EX/MEM control outputs latch 0 (data don't-care); in BUSY/DONE aborts MDU, HI/LO unchanged, -> IDLE, stall=0 same cycle. flush beats stall.

## Timing
- Reset: all outputs 0, HI=LO=0, FSM IDLE, stall=0.
- ALU/branch instructions: 1 cycle, results on EX/MEM outputs after the next rising edge.
- Mult/div: stall high combinationally in the IDLE start cycle plus MDU_ITER BUSY cycles (33 total at default); HI/LO valid at the edge ending the last BUSY cycle; instruction leaves in DONE cycle (34 cycles in EX).
- mfhi/mflo directly following a mult/div sees the new HI/LO (no forwarding needed).
- While stall=1, EX/MEM latches a bubble (all control 0) each cycle.
- reset asserted mid-operation: immediate return to reset state, no partial HI/LO write.

## Structure
- `definitions.vh`: `WORD, funct codes, ALUOp encodings, MDU state encodings.
- Sub-module mul_div_unit: FSM, counter, 64-bit shift accumulator, HI/LO, start/abort/busy/done ports.
- EX/MEM register as sub-module buffer_exmem, mirroring buffer_memwb.

## Test plan
- add: ReadData1=5, ReadData2=7, funct 20 -> next cycle ALUResult_out=12, zero=0, RegDstAddress_out=Rd.
- beq path: ALUOp 01, ReadData1=ReadData2=9, PCplus4=0x100, imm=4 -> zero=1, BranchTarget=0x110, Branch=1.
- mult: 0xFFFFFFFE x 3 signed -> stall high 33 cycles, then mflo=0xFFFFFFFA, mfhi=0xFFFFFFFF.
- divu 7/0 -> LO=0xFFFFFFFF, HI=7; div -7/2 -> LO=-3, HI=-1.
- flush at BUSY cycle 10 of mult -> stall drops same cycle, HI/LO retain prior values, EX/MEM control 0.
- reset low during BUSY -> all outputs 0, FSM IDLE; subsequent add executes normally.
